// File: rtl/dm_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller and its store shaper.
package dm_access_ctrl_pkg;

  // Load-type selectors, as consumed by the load-data extender
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_BU = 3'b001;
  localparam logic [2:0] LD_B  = 3'b010;
  localparam logic [2:0] LD_HU = 3'b011;
  localparam logic [2:0] LD_H  = 3'b100;

  // Store sizes
  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_W = 2'b10;

  // Default data-memory window
  localparam logic [31:0] DM_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] DM_SIZE_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  // Natural-alignment check; byte accesses and unknown load types never fault.
  function automatic logic addr_misaligned(input logic       we,
                                           input logic [2:0] ldsel,
                                           input logic [1:0] stsz,
                                           input logic [1:0] alow);
    logic r;
    r = 1'b0;
    if (we) begin
      case (stsz)
        ST_H:    r = alow[0];
        ST_W:    r = |alow;
        default: r = 1'b0;
      endcase
    end else begin
      case (ldsel)
        LD_W:        r = |alow;
        LD_HU, LD_H: r = alow[0];
        default:     r = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_store.sv
// Combinational store shaper: byte enables plus lane-replicated write data.
module dm_store_shaper
  import dm_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_stsz,
  input  logic [1:0]  i_addrlow,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata
);

  // Replicate the right-justified datum across every lane it may land in
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    case (i_stsz)
      ST_B: begin
        o_be    = 4'b0001 << i_addrlow;
        o_wdata = {4{i_wdata[7:0]}};
      end
      ST_H: begin
        o_be    = i_addrlow[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      ST_W: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage sequencer for a single-port synchronous data memory with fixed
// read latency: address checks, store shaping, pipeline stall, and extender
// control aligned with returning read data.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int          MEM_LAT = 2,
  parameter logic [31:0] DM_BASE = DM_BASE_DEF,
  parameter logic [31:0] DM_SIZE = DM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_ldsel,
  input  logic [1:0]  req_stsz,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  ext_addrlow,
  output logic [2:0]  ext_ldsel,
  output logic        done,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] bad_addr
);

  localparam logic [2:0]  LAT_M1 = 3'(MEM_LAT - 1);
  localparam logic [32:0] LO     = {1'b0, DM_BASE};

  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic [1:0]  r_addrlow;
  logic [2:0]  r_ldsel;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [32:0] w_off;
  logic        w_in_range;
  logic        w_err;
  logic        w_accept;

  dm_store_shaper u_shaper (
    .i_stsz    (req_stsz),
    .i_addrlow (req_addr[1:0]),
    .i_wdata   (req_wdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata)
  );

  // Borrow out of the offset subtraction means the address is below the window
  assign w_off      = {1'b0, req_addr} - LO;
  assign w_in_range = !w_off[32] && (w_off[31:0] < DM_SIZE);
  assign w_err      = addr_misaligned(req_we, req_ldsel, req_stsz, req_addr[1:0]) || !w_in_range;
  assign w_accept   = (r_state == S_IDLE) && req_valid && !flush && !w_err;

  assign mem_addr    = r_waddr;
  assign mem_wdata   = r_wdata;
  assign ext_addrlow = r_addrlow;
  assign ext_ldsel   = r_ldsel;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Latency counter: loaded on issue, counts down through WAIT
  always_ff @(posedge clk) begin
    if (reset)                                 r_cnt <= 3'd0;
    else if (r_state == S_ISSUE)               r_cnt <= LAT_M1;
    else if (r_state == S_WAIT && r_cnt != 0)  r_cnt <= r_cnt - 3'd1;
  end

  // Capture the accepted op; extender controls only move on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_be      <= 4'b0000;
      r_waddr   <= 32'h0;
      r_wdata   <= 32'h0;
      r_addrlow <= 2'b00;
      r_ldsel   <= LD_W;
    end else if (w_accept) begin
      r_we      <= req_we;
      r_be      <= w_be;
      r_waddr   <= {req_addr[31:2], 2'b00};
      r_wdata   <= w_wdata;
      r_addrlow <= req_addr[1:0];
      r_ldsel   <= req_we ? LD_W : req_ldsel;
    end
  end

  // Next-state and per-state outputs; a WAIT entered with count 1 is the last
  always_comb begin
    w_next   = r_state;
    stall    = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 4'b0000;
    done     = 1'b0;
    exc_adel = 1'b0;
    exc_ades = 1'b0;
    bad_addr = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          if (w_err) begin
            exc_adel = !req_we;
            exc_ades = req_we;
            bad_addr = req_addr;
          end else begin
            stall  = 1'b1;
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        stall  = 1'b1;
        mem_en = 1'b1;
        mem_we = r_we ? r_be : 4'b0000;
        if (flush)             w_next = S_IDLE;
        else if (MEM_LAT == 1) w_next = S_RESP;
        else                   w_next = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (flush)            w_next = S_IDLE;
        else if (r_cnt <= 1)  w_next = S_RESP;
      end
      S_RESP: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: transaction-level timing model with a
// per-cycle compare, a bench-side memory and extender, and directed literal pins.
module tb_dm_access_ctrl;
  import dm_access_ctrl_pkg::*;

  localparam int LAT = 2;
  localparam longint BASE = 0;
  localparam longint SIZE = 32'h3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_ldsel = 3'b000;
  logic [1:0]  req_stsz = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        flush = 1'b0;
  logic        stall, mem_en, done, exc_adel, exc_ades;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, bad_addr;
  logic [1:0]  ext_addrlow;
  logic [2:0]  ext_ldsel;

  always #5 clk = ~clk;

  dm_access_ctrl #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_ldsel(req_ldsel), .req_stsz(req_stsz), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush), .stall(stall), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ext_addrlow(ext_addrlow), .ext_ldsel(ext_ldsel), .done(done),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bad_addr(bad_addr)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] tb_mem [0:3071];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] al, input logic [2:0] ls);
    logic [31:0] s;
    logic [15:0] h;
    s = w >> (8 * al);
    h = al[1] ? w[31:16] : w[15:0];
    case (ls)
      LD_BU:   return {24'h0, s[7:0]};
      LD_B:    return {{24{s[7]}}, s[7:0]};
      LD_HU:   return {16'h0, h};
      LD_H:    return {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic int acc_size(input logic we, input logic [2:0] ls, input logic [1:0] sz);
    if (we) return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 1;
    return (ls == LD_W) ? 4 : (ls == LD_HU || ls == LD_H) ? 2 : 1;
  endfunction

  function automatic logic addr_bad(input logic we, input logic [2:0] ls, input logic [1:0] sz, input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return ((int'(a[1:0]) % acc_size(we, ls, sz)) != 0) || (ua < BASE) || (ua >= BASE + SIZE);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 4'(1 << a[1:0]);
      2'd1:    return a[1] ? 4'hC : 4'h3;
      2'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Model: age = cycles since the op was accepted (-1 = no op in flight)
  int          age = -1;
  logic        m_we;
  logic [2:0]  m_ls;
  logic [1:0]  m_sz;
  logic [31:0] m_a, m_wd, m_rword;
  logic [1:0]  m_al_reg = 2'b00;
  logic [2:0]  m_ls_reg = 3'b000;
  logic        e_stall, e_en, e_done, e_adel, e_ades;
  logic [3:0]  e_we;
  logic [31:0] e_bad, mask, tmp;

  always @(negedge clk) begin
    e_stall = 0; e_en = 0; e_done = 0; e_adel = 0; e_ades = 0; e_we = 0; e_bad = 0;
    if (age < 0) begin
      if (req_valid && !flush) begin
        if (addr_bad(req_we, req_ldsel, req_stsz, req_addr)) begin
          e_adel = !req_we; e_ades = req_we; e_bad = req_addr;
        end else e_stall = 1;
      end
    end else if (age == 1) begin
      e_stall = 1; e_en = 1;
      e_we = m_we ? exp_be(m_sz, m_a) : 4'h0;
      chk("mem_addr", mem_addr, {m_a[31:2], 2'b00});
      if (m_we) chk("mem_wdata", mem_wdata, exp_wd(m_sz, m_wd));
    end else if (age < 1 + LAT) begin
      e_stall = 1;
    end else begin
      e_done = 1;
      if (!m_we) chk("load_data", extend(m_rword, ext_addrlow, ext_ldsel), extend(m_rword, m_al_reg, m_ls_reg));
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("done", 32'(done), 32'(e_done));
    chk("exc_adel", 32'(exc_adel), 32'(e_adel));
    chk("exc_ades", 32'(exc_ades), 32'(e_ades));
    chk("bad_addr", bad_addr, e_bad);
    chk("ext_addrlow", 32'(ext_addrlow), 32'(m_al_reg));
    chk("ext_ldsel", 32'(ext_ldsel), 32'(m_ls_reg));
    // advance the model to the next cycle
    if (reset) begin
      age = -1; m_al_reg = 2'b00; m_ls_reg = 3'b000;
    end else if (age < 0) begin
      if (e_stall) begin
        age = 1; m_we = req_we; m_ls = req_ldsel; m_sz = req_stsz; m_a = req_addr; m_wd = req_wdata;
        m_al_reg = req_addr[1:0]; m_ls_reg = req_we ? 3'b000 : req_ldsel;
      end
    end else if (age == 1) begin
      if (m_we) begin
        mask = 32'h0;
        for (int i = 0; i < 4; i++) if (e_we[i]) mask = mask | (32'hFF << (8 * i));
        tmp = tb_mem[int'(m_a[31:2])];
        tb_mem[int'(m_a[31:2])] = (tmp & ~mask) | (exp_wd(m_sz, m_wd) & mask);
      end else m_rword = tb_mem[int'(m_a[31:2])];
      age = flush ? -1 : 2;
    end else if (age == 1 + LAT) age = -1;
    else if (flush) age = -1;
    else age++;
  end

  int          ns, ec, dc;
  logic [3:0]  cwe;
  logic [31:0] cwd, cad, cld, cbad;
  logic        cexl, cexs;
  logic [1:0]  cal;
  logic [2:0]  cls;

  // Present one request (caller is just past a rising edge) and observe it to completion
  task automatic do_op(input logic we, input logic [2:0] ls, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    logic fin;
    req_valid = 1; req_we = we; req_ldsel = ls; req_stsz = sz; req_addr = a; req_wdata = wd;
    ns = 0; ec = -1; dc = -1; cwe = 0; cwd = 0; cad = 0; cld = 0; cbad = 0;
    cexl = 0; cexs = 0; cal = 0; cls = 0; fin = 0;
    for (int k = 0; k < 20 && !fin; k++) begin
      @(negedge clk);
      if (stall) ns++;
      if (mem_en) begin ec = k; cwe = mem_we; cwd = mem_wdata; cad = mem_addr; end
      if (exc_adel || exc_ades) begin cexl = exc_adel; cexs = exc_ades; cbad = bad_addr; end
      if (done) begin
        dc = k; cal = ext_addrlow; cls = ext_ldsel;
        cld = extend(tb_mem[int'(cad[31:2])], ext_addrlow, ext_ldsel);
      end
      if (!stall) fin = 1;
    end
    if (!fin) chk("op_timeout", 32'(fin), 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 3072; i++) tb_mem[i] = (i * 32'h0001_0001) ^ 32'h5A5A_0000;
    tb_mem[4] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);       chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);     chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);    chk("rst_ext_addrlow", 32'(ext_addrlow), 0);
    chk("rst_ext_ldsel", 32'(ext_ldsel), 0); chk("rst_done", 32'(done), 0);
    chk("rst_bad_addr", bad_addr, 0);
    @(posedge clk); #1;
    reset = 0;

    do_op(1'b0, LD_W, ST_B, 32'h0000_0010, 32'h0);
    chk("lw_stall_cycles", 32'(ns), 3); chk("lw_en_cycle", 32'(ec), 1);
    chk("lw_done_cycle", 32'(dc), 3);   chk("lw_ldsel", 32'(cls), 0);
    chk("lw_addrlow", 32'(cal), 0);     chk("lw_data", cld, 32'hDEAD_BEEF);

    tb_mem[4] = 32'h80FF_FF7F;
    do_op(1'b0, LD_B, ST_B, 32'h0000_0013, 32'h0);
    chk("lb_addrlow", 32'(cal), 3); chk("lb_ldsel", 32'(cls), 2); chk("lb_data", cld, 32'hFFFF_FF80);

    do_op(1'b1, LD_W, ST_B, 32'h0000_0006, 32'h0000_00A5);
    chk("sb_we", 32'(cwe), 32'h4); chk("sb_wdata", cwd, 32'hA5A5_A5A5); chk("sb_addr", cad, 32'h4);
    chk("sb_ldsel", 32'(cls), 0);

    do_op(1'b1, LD_W, ST_H, 32'h0000_000A, 32'h0000_8001);
    chk("sh_we", 32'(cwe), 32'hC); chk("sh_wdata", cwd, 32'h8001_8001);
    do_op(1'b0, LD_H, ST_B, 32'h0000_000A, 32'h0);
    chk("lh_data", cld, 32'hFFFF_8001);
    do_op(1'b0, LD_HU, ST_B, 32'h0000_0008, 32'h0);
    chk("lhu_data", cld, 32'h0000_0002);

    do_op(1'b0, LD_H, ST_B, 32'h0000_0001, 32'h0);
    chk("adel_flag", 32'(cexl), 1); chk("adel_bad", cbad, 32'h1);
    chk("adel_stall", 32'(ns), 0);  chk("adel_no_en", 32'(ec), 32'hFFFF_FFFF);

    do_op(1'b1, LD_W, ST_W, 32'h0000_3000, 32'h1);
    chk("ades_flag", 32'(cexs), 1); chk("ades_bad", cbad, 32'h3000);

    do_op(1'b1, LD_W, ST_W, 32'h0000_2FFC, 32'h1122_3344);
    chk("sw_we", 32'(cwe), 32'hF);
    do_op(1'b0, LD_W, ST_B, 32'h0000_2FFC, 32'h0);
    chk("lw_top_data", cld, 32'h1122_3344);

    // flush while idle suppresses the fault
    req_valid = 1; req_we = 0; req_ldsel = LD_H; req_addr = 32'h1; flush = 1;
    @(negedge clk);
    chk("flush_idle_adel", 32'(exc_adel), 0); chk("flush_idle_stall", 32'(stall), 0);
    @(posedge clk); #1;
    flush = 0; req_valid = 0;

    // flush in the first WAIT cycle of a load
    req_valid = 1; req_we = 0; req_ldsel = LD_W; req_addr = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    @(negedge clk);
    chk("flush_wait_done", 32'(done), 0); chk("flush_wait_stall", 32'(stall), 0);
    @(posedge clk); #1;
    do_op(1'b0, LD_W, ST_B, 32'h0000_0010, 32'h0);
    chk("after_flush_done", 32'(dc), 3); chk("after_flush_data", cld, 32'h80FF_FF7F);

    // reset while in WAIT
    req_valid = 1; req_we = 0; req_ldsel = LD_BU; req_addr = 32'h2FFD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; req_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rw_stall", 32'(stall), 0);        chk("rw_done", 32'(done), 0);
    chk("rw_mem_en", 32'(mem_en), 0);      chk("rw_mem_addr", mem_addr, 0);
    chk("rw_mem_wdata", mem_wdata, 0);     chk("rw_ext_addrlow", 32'(ext_addrlow), 0);
    chk("rw_ext_ldsel", 32'(ext_ldsel), 0); chk("rw_bad_addr", bad_addr, 0);
    @(posedge clk); #1;
    do_op(1'b1, LD_W, ST_B, 32'h0000_2FFF, 32'h0000_005C);
    chk("sb_top_we", 32'(cwe), 32'h8); chk("sb_top_wdata", cwd, 32'h5C5C_5C5C);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Multi-cycle sequencer between the MEM-stage memory request and the single-port synchronous data memory, which has fixed read latency.
- Checks alignment and range, and raises AdEL/AdES.
- Generates store byte-enables and replicated write data.
- Holds the pipeline with stall until the access completes.
- Registers the Addrlow/LDsel control so the load-data extender receives it aligned with returning read data.

Parameters:
- MEM_LAT, 2, cycles from issue cycle to the cycle read data is valid; legal range 1..7.
- DM_BASE, 32'h0000_0000, first legal data-memory byte address.
- DM_SIZE, 32'h0000_3000, data-memory size in bytes; legal addresses are DM_BASE..DM_BASE+DM_SIZE-1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  MEM stage holds a memory op; held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_ldsel  in  3  load type: 000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh.
- req_stsz  in  2  store size: 00 sb, 01 sh, 10 sw.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- flush  in  1  kill the current op (exception or interrupt in a later stage).
- stall  out  1  freeze IF/ID/EX/MEM.
- mem_en  out  1  memory access strobe, one cycle per op.
- mem_we  out  4  byte write enables.
- mem_addr  out  32  word address, req_addr with bits [1:0] = 00.
- mem_wdata  out  32  lane-replicated store data.
- ext_addrlow  out  2  to the extender's Addrlow input.
- ext_ldsel  out  3  to the extender's LDsel input.
- done  out  1  op complete this cycle; read data valid when the op is a load.
- exc_adel  out  1  load address error.
- exc_ades  out  1  store address error.
- bad_addr  out  32  faulting address.

Behaviour:
- Reset: state=IDLE, counter=0. All outputs 0 except mem_addr, mem_wdata and bad_addr, which are 0 as well.
- A reset mid-op abandons the op; no done is raised.
- States: IDLE, ISSUE, WAIT, RESP.
- Address errors are checked combinationally in IDLE when req_valid=1:
  - Misaligned: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]=1.
  - Out of range: address outside the DM range.
  - On an error, load raises exc_adel and store raises exc_ades in the same cycle. bad_addr=req_addr, stall=0, no memory access, state stays IDLE.
- IDLE to ISSUE: req_valid=1, no error, flush=0. The controller latches we, ldsel, stsz, addr[1:0], word address and the shaped wdata. stall=1 in this cycle.
- ISSUE (one cycle):
  - mem_en=1. For stores, mem_we is set:
    - sb: 4'b0001 << addr[1:0].
    - sh: 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1.
    - sw: 4'b1111.
  - mem_wdata for stores: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
  - Counter loads MEM_LAT-1. Next state is WAIT, or RESP if MEM_LAT=1.
  - stall=1.
- WAIT: counter decrements each cycle. At 0 the next state is RESP. stall=1, mem_en=0, mem_we=0.
- RESP (one cycle): done=1, stall=0. ext_addrlow/ext_ldsel hold the latched values. For stores ext_ldsel=000. Next state IDLE.
- ext_addrlow/ext_ldsel are registered and change only on IDLE to ISSUE.
- Load latency: the request is presented in cycle 0, the issue cycle is cycle 1, done occurs in cycle 1+MEM_LAT. The pipeline stalls 1+MEM_LAT cycles.
- Back-to-back ops: RESP goes to IDLE, so the next op is sampled the cycle after RESP. There is no overlap.
- flush handling:
  - In IDLE: the request is suppressed and no exception flag is raised.
  - In ISSUE: the store still writes. The FSM then returns to IDLE, so done=0 and stall=0 from the next cycle.
  - In WAIT: go to IDLE; no done.
  - In RESP: no effect.
- exc_* and done are never high in the same cycle.

Decomposition:
- Shared package holds:
  - LDsel encodings (LD_W, LD_BU, LD_B, LD_HU, LD_H).
  - Store-size encodings (ST_B, ST_H, ST_W).
  - FSM state encoding.
  - Default DM range constants.
- One sub-module, dm_store_shaper: a combinational block mapping (stsz, addr[1:0], wdata) to (mem_we, mem_wdata). It is reused by the bridge for device writes.

Test Plan:
- lw at 0x0000_0010, MEM_LAT=2, mem returns 0xDEADBEEF at issue+2: stall high for cycles 0–2; mem_en only in cycle 1; done in cycle 3 with ext_ldsel=000, ext_addrlow=00.
- lb at 0x0000_0013: ext_addrlow=11, ext_ldsel=010. With returned word 0x80FF_FF7F the extender output is 0xFFFF_FF80.
- sb, wdata 0x0000_00A5, addr 0x0000_0006: mem_we=0100, mem_wdata=0xA5A5_A5A5, mem_addr=0x0000_0004.
- Errors:
  - lh at 0x0000_0001: exc_adel=1 and bad_addr=0x0000_0001 in the same cycle, stall=0, mem_en never asserted.
  - sw at 0x0000_3000: exc_ades=1.
- Kills:
  - flush in the first WAIT cycle of a load: no done, state IDLE next cycle, and the next request is accepted normally.
  - reset in WAIT: all outputs 0 next cycle.
